// File: rtl/boot_loader.sv
// boot_loader: pops a length-prefixed image from the UART RX FIFO into RAM
// starting at word 0, then releases the CPU and hands it the RAM port.
module boot_loader #(
  parameter int NUM_WORDS = 3584
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_empty,
  input  logic [7:0]  uart_rdata,
  output logic        rd_uart,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_re,
  output logic [3:0]  ram_we,
  output logic        cpu_reset,
  output logic        loaded,
  output logic        error
);

  typedef enum logic [2:0] {HDR, DATA, WR, RUN, ERR} state_t;

  state_t      state, state_nx;
  logic [1:0]  byte_cnt;
  logic [29:0] waddr;
  logic [29:0] waddr_inc;
  logic [31:0] len_q;
  logic [31:0] word_q;
  logic [31:0] len_full;
  logic        pop;
  logic        last_byte;

  // Only the collecting states consume bytes; reset wins over a pending pop.
  assign pop       = ((state == HDR) || (state == DATA)) && !rx_empty && !reset;
  assign rd_uart   = pop;
  assign last_byte = pop && (byte_cnt == 2'd3);
  assign waddr_inc = waddr + 30'd1;
  // Length as it will be once the top byte lands; lets HDR decide on the same edge.
  assign len_full  = {uart_rdata, len_q[23:0]};

  // State register plus byte/word/length datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HDR;
      byte_cnt <= 2'd0;
      waddr    <= 30'd0;
      len_q    <= 32'd0;
      word_q   <= 32'd0;
    end else begin
      state <= state_nx;
      if (pop) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == HDR) len_q[{byte_cnt, 3'b000} +: 8]  <= uart_rdata;
        else              word_q[{byte_cnt, 3'b000} +: 8] <= uart_rdata;
      end
      if (state == WR) waddr <= waddr_inc;
    end
  end

  // Next state and RAM-port / CPU-control outputs.
  always_comb begin
    state_nx  = state;
    ram_addr  = waddr;
    ram_wdata = word_q;
    ram_re    = 1'b0;
    ram_we    = 4'b0000;
    cpu_reset = 1'b1;
    loaded    = 1'b0;
    error     = 1'b0;
    case (state)
      HDR: begin
        if (last_byte) begin
          if (len_full == 32'd0)                 state_nx = RUN;
          else if (len_full > 32'(NUM_WORDS))    state_nx = ERR;
          else                                   state_nx = DATA;
        end
      end
      DATA: begin
        if (last_byte) state_nx = WR;
      end
      WR: begin
        ram_we = 4'b1111;
        // Length is 32 bits; zero-extend the address so the compare is exact.
        if ({2'b00, waddr_inc} == len_q) state_nx = RUN;
        else                             state_nx = DATA;
      end
      RUN: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_re    = cpu_re;
        ram_we    = cpu_we;
        cpu_reset = 1'b0;
        loaded    = 1'b1;
      end
      ERR: begin
        error = 1'b1;
      end
      default: state_nx = HDR;
    endcase
  end

endmodule
